// File: rtl/bomberman_axil_pkg.sv
// Shared constants and helpers for the bomberman AXI4-Lite register slave.
// Imported by the write-capture block and the top-level register file.
package bomberman_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         ADDR_LSB    = 2;

    function automatic logic [31:0] strb_merge(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  wstrb
    );
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_wr_capture.sv
// AXI4-Lite write-channel capture: holds AW/W independently and
// emits a single-cycle commit once both halves are present.
module axil_wr_capture
    import bomberman_axil_pkg::*;
#(
    parameter int IDX_W    = 4,
    parameter int NUM_REGS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] aw_idx,
    input  logic             aw_valid,
    output logic             aw_ready,
    input  logic [31:0]      w_data,
    input  logic [3:0]       w_strb,
    input  logic             w_valid,
    output logic             w_ready,
    output logic [1:0]       b_resp,
    output logic             b_valid,
    input  logic             b_ready,
    output logic             commit,
    output logic [IDX_W-1:0] commit_idx,
    output logic [31:0]      commit_data,
    output logic [3:0]       commit_strb
);

    logic             aw_held_q, aw_held_d;
    logic             w_held_q, w_held_d;
    logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
    logic [31:0]      w_data_q, w_data_d;
    logic [3:0]       w_strb_q, w_strb_d;
    logic             b_valid_q, b_valid_d;
    logic [1:0]       b_resp_q, b_resp_d;
    logic             aw_ready_q, aw_ready_d;
    logic             w_ready_q, w_ready_d;
    logic             aw_hs, w_hs, commit_hit;

    always_comb begin
        aw_hs       = aw_valid & aw_ready_q;
        w_hs        = w_valid & w_ready_q;
        commit      = (aw_hs | aw_held_q) & (w_hs | w_held_q);
        commit_idx  = aw_hs ? aw_idx : aw_idx_q;
        commit_data = w_hs ? w_data : w_data_q;
        commit_strb = w_hs ? w_strb : w_strb_q;
        commit_hit  = 32'(commit_idx) < 32'(NUM_REGS);

        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_idx_d  = commit_idx;
        w_data_d  = commit_data;
        w_strb_d  = commit_strb;
        b_valid_d = b_valid_q;
        b_resp_d  = b_resp_q;

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            b_valid_d = 1'b1;
            b_resp_d  = commit_hit ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs) aw_held_d = 1'b1;
            if (w_hs) w_held_d = 1'b1;
            if (b_valid_q & b_ready) b_valid_d = 1'b0;
        end

        // Readies are registered so they read low while in reset.
        aw_ready_d = !aw_held_d & !b_valid_d;
        w_ready_d  = !w_held_d & !b_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
        end else begin
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_idx_q   <= aw_idx_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
        end
    end

    assign aw_ready = aw_ready_q;
    assign w_ready  = w_ready_q;
    assign b_valid  = b_valid_q;
    assign b_resp   = b_resp_q;

endmodule

// File: rtl/axil_bomberman_reg_slave.sv
// AXI4-Lite register file for the bomberman controller: NUM_REGS
// 32-bit control registers plus per-register write pulses.
module axil_bomberman_reg_slave
    import bomberman_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS           = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]          reg_q,
    output logic [NUM_REGS-1:0]             reg_wr_pulse
);

    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

    logic [NUM_REGS-1:0][31:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]       pulse_q, pulse_d;
    logic                      rvalid_q, rvalid_d;
    logic [31:0]               rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;
    logic                      arready_q, arready_d;

    logic             commit;
    logic [IDX_W-1:0] commit_idx;
    logic [31:0]      commit_data;
    logic [3:0]       commit_strb;
    logic [IDX_W-1:0] ar_idx;
    logic             ar_hs;
    logic             unused_bits;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[ADDR_LSB-1:0],
                           S_AXI_ARADDR[ADDR_LSB-1:0]};

    axil_wr_capture #(
        .IDX_W    (IDX_W),
        .NUM_REGS (NUM_REGS)
    ) u_wr_capture (
        .clk         (ACLK),
        .rst         (ARESET),
        .aw_idx      (S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB]),
        .aw_valid    (S_AXI_AWVALID),
        .aw_ready    (S_AXI_AWREADY),
        .w_data      (S_AXI_WDATA),
        .w_strb      (S_AXI_WSTRB),
        .w_valid     (S_AXI_WVALID),
        .w_ready     (S_AXI_WREADY),
        .b_resp      (S_AXI_BRESP),
        .b_valid     (S_AXI_BVALID),
        .b_ready     (S_AXI_BREADY),
        .commit      (commit),
        .commit_idx  (commit_idx),
        .commit_data (commit_data),
        .commit_strb (commit_strb)
    );

    always_comb begin
        regs_d  = regs_q;
        pulse_d = '0;
        if (commit) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (commit_idx == IDX_W'(k)) begin
                    regs_d[k]  = strb_merge(regs_q[k], commit_data, commit_strb);
                    pulse_d[k] = 1'b1;
                end
            end
        end
    end

    assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign ar_hs  = S_AXI_ARVALID & arready_q;

    // Reads sample regs_q, so a same-edge write returns the old value.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q & S_AXI_RREADY) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (ar_idx == IDX_W'(k)) begin
                    rdata_d = regs_q[k];
                    rresp_d = RESP_OKAY;
                end
            end
        end
        arready_d = !rvalid_d;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            regs_q    <= '0;
            pulse_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            pulse_q   <= pulse_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            arready_q <= arready_d;
        end
    end

    assign reg_q         = regs_q;
    assign reg_wr_pulse  = pulse_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axil_bomberman_reg_slave.sv
// Bench for axil_bomberman_reg_slave: directed cases plus random
// traffic, all outputs compared each cycle against a queue model.
module tb_axil_bomberman_reg_slave;

    logic         clk = 1'b0;
    logic         ARESET = 1'b1;
    logic [5:0]   AWADDR = '0;
    logic [2:0]   AWPROT = '0;
    logic         AWVALID = 1'b0;
    logic         AWREADY;
    logic [31:0]  WDATA = '0;
    logic [3:0]   WSTRB = '0;
    logic         WVALID = 1'b0;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY = 1'b0;
    logic [5:0]   ARADDR = '0;
    logic [2:0]   ARPROT = '0;
    logic         ARVALID = 1'b0;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY = 1'b0;
    logic [127:0] reg_q;
    logic [3:0]   reg_wr_pulse;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axil_bomberman_reg_slave dut (
        .ACLK          (clk),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (AWADDR),
        .S_AXI_AWPROT  (AWPROT),
        .S_AXI_AWVALID (AWVALID),
        .S_AXI_AWREADY (AWREADY),
        .S_AXI_WDATA   (WDATA),
        .S_AXI_WSTRB   (WSTRB),
        .S_AXI_WVALID  (WVALID),
        .S_AXI_WREADY  (WREADY),
        .S_AXI_BRESP   (BRESP),
        .S_AXI_BVALID  (BVALID),
        .S_AXI_BREADY  (BREADY),
        .S_AXI_ARADDR  (ARADDR),
        .S_AXI_ARPROT  (ARPROT),
        .S_AXI_ARVALID (ARVALID),
        .S_AXI_ARREADY (ARREADY),
        .S_AXI_RDATA   (RDATA),
        .S_AXI_RRESP   (RRESP),
        .S_AXI_RVALID  (RVALID),
        .S_AXI_RREADY  (RREADY),
        .reg_q         (reg_q),
        .reg_wr_pulse  (reg_wr_pulse)
    );

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: transactions as queues, registers as an array.
    logic [31:0] m_regs [4];
    logic [5:0]  awq [$];
    logic [35:0] wq [$];
    logic [1:0]  bq [$];
    logic [33:0] rq [$];
    bit          ready_ok;
    logic [3:0]  m_pulse;

    function automatic bit exp_awready();
        return ready_ok && awq.size() == 0 && bq.size() == 0;
    endfunction
    function automatic bit exp_wready();
        return ready_ok && wq.size() == 0 && bq.size() == 0;
    endfunction
    function automatic bit exp_arready();
        return ready_ok && rq.size() == 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_regs[k] = '0;
        awq.delete(); wq.delete(); bq.delete(); rq.delete();
        ready_ok = 0;
        m_pulse = '0;
    endtask

    task automatic model_step();
        bit aw_rdy, w_rdy, ar_rdy;
        int idx;
        logic [5:0] a;
        logic [35:0] w;
        logic [31:0] mask;
        aw_rdy = exp_awready();
        w_rdy = exp_wready();
        ar_rdy = exp_arready();
        m_pulse = '0;
        if (bq.size() > 0 && BREADY) void'(bq.pop_front());
        if (rq.size() > 0 && RREADY) void'(rq.pop_front());
        if (ARVALID && ar_rdy) begin
            idx = int'(ARADDR) / 4;
            if (idx < 4) rq.push_back({2'b00, m_regs[idx]});
            else rq.push_back({2'b10, 32'h0});
        end
        if (AWVALID && aw_rdy) awq.push_back(AWADDR);
        if (WVALID && w_rdy) wq.push_back({WSTRB, WDATA});
        if (awq.size() > 0 && wq.size() > 0) begin
            a = awq.pop_front();
            w = wq.pop_front();
            idx = int'(a) / 4;
            if (idx < 4) begin
                mask = '0;
                for (int b = 0; b < 4; b++)
                    if (w[32+b]) mask = mask | (32'hFF << (8*b));
                m_regs[idx] = (m_regs[idx] & ~mask) | (w[31:0] & mask);
                m_pulse[idx] = 1'b1;
                bq.push_back(2'b00);
            end else begin
                bq.push_back(2'b10);
            end
        end
        ready_ok = 1;
    endtask

    initial forever begin
        @(posedge clk or posedge ARESET);
        if (ARESET) model_reset();
        else model_step();
    end

    task automatic check_outputs();
        logic [127:0] flat;
        for (int k = 0; k < 4; k++) flat[32*k +: 32] = m_regs[k];
        chk("awready", AWREADY, exp_awready());
        chk("wready", WREADY, exp_wready());
        chk("arready", ARREADY, exp_arready());
        chk("bvalid", BVALID, bq.size() > 0);
        chk("rvalid", RVALID, rq.size() > 0);
        if (bq.size() > 0) chk("bresp", BRESP, bq[0]);
        if (rq.size() > 0) begin
            chk("rdata", RDATA, rq[0][31:0]);
            chk("rresp", RRESP, rq[0][33:32]);
        end
        chk("reg_q", reg_q, flat);
        chk("reg_wr_pulse", reg_wr_pulse, m_pulse);
        if (ARESET) begin
            chk("rst_rdata", RDATA, 0);
            chk("rst_bresp", BRESP, 0);
            chk("rst_rresp", RRESP, 0);
        end
    endtask

    initial forever begin
        @(negedge clk);
        check_outputs();
    end

    // All drivers start and end on a falling edge.
    task automatic send_aw(input logic [5:0] a);
        int n = 0;
        AWADDR = a;
        AWVALID = 1'b1;
        while (!AWREADY && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("aw_timeout", 1, 0);
        @(negedge clk);
        AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        WDATA = d;
        WSTRB = s;
        WVALID = 1'b1;
        while (!WREADY && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("w_timeout", 1, 0);
        @(negedge clk);
        WVALID = 1'b0;
    endtask

    task automatic wait_b(input int dly, output logic [1:0] resp);
        int n = 0;
        while (!BVALID && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("b_timeout", 1, 0);
        resp = BRESP;
        repeat (dly) @(negedge clk);
        BREADY = 1'b1;
        @(negedge clk);
        BREADY = 1'b0;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int awd,
                            input int wd, input int bd,
                            output logic [1:0] resp);
        fork
            begin repeat (awd) @(negedge clk); send_aw(a); end
            begin repeat (wd) @(negedge clk); send_w(d, s); end
        join
        wait_b(bd, resp);
    endtask

    task automatic do_read(input logic [5:0] a, input int rd,
                           output logic [31:0] data,
                           output logic [1:0] resp);
        int n = 0;
        ARADDR = a;
        ARVALID = 1'b1;
        while (!ARREADY && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("ar_timeout", 1, 0);
        @(negedge clk);
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("r_timeout", 1, 0);
        data = RDATA;
        resp = RRESP;
        repeat (rd) @(negedge clk);
        RREADY = 1'b1;
        @(negedge clk);
        RREADY = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp, rresp;
        logic [31:0] data;
        logic [5:0]  a;
        logic [127:0] snap;

        repeat (3) @(negedge clk);
        chk("rst_awready", AWREADY, 0);
        chk("rst_reg_q", reg_q, 0);
        #2 ARESET = 1'b0;
        @(negedge clk);
        chk("awready_after_rst", AWREADY, 1);
        chk("arready_after_rst", ARREADY, 1);

        for (int k = 0; k < 4; k++) begin
            do_write(6'(4*k), 32'(k+1), 4'hF, 0, 0, 0, resp);
            chk("wr_okay", resp, 2'b00);
        end
        chk("reg_q_1234", reg_q, 128'h00000004_00000003_00000002_00000001);
        for (int k = 0; k < 4; k++) begin
            do_read(6'(4*k), 0, data, rresp);
            chk("rd_1234", data, 32'(k+1));
            chk("rd_okay", rresp, 2'b00);
        end

        fork
            do_write(6'h08, 32'hDEADBEEF, 4'hF, 0, 3, 0, resp);
            begin repeat (2) @(negedge clk); chk("aw_held_ready", AWREADY, 0); end
        join
        chk("reg2_aw_first", reg_q[95:64], 32'hDEADBEEF);
        do_write(6'h08, 32'hCAFEF00D, 4'hF, 3, 0, 0, resp);
        chk("reg2_w_first", reg_q[95:64], 32'hCAFEF00D);

        do_write(6'h04, 32'h11223344, 4'hF, 0, 0, 0, resp);
        do_write(6'h05, 32'hAABBCCDD, 4'b0101, 0, 0, 1, resp);
        chk("reg1_strb", reg_q[63:32], 32'h11BB33DD);
        do_write(6'h04, 32'hFFFFFFFF, 4'b0000, 1, 0, 0, resp);
        chk("reg1_strb0", reg_q[63:32], 32'h11BB33DD);

        snap = reg_q;
        do_write(6'h10, 32'h12345678, 4'hF, 0, 0, 0, resp);
        chk("wr_slverr", resp, 2'b10);
        chk("wr_slverr_noupd", reg_q, snap);
        do_read(6'h3C, 0, data, rresp);
        chk("rd_slverr_data", data, 0);
        chk("rd_slverr_resp", rresp, 2'b10);

        fork
            do_write(6'h0C, 32'h55AA55AA, 4'hF, 0, 0, 10, resp);
            begin
                repeat (4) @(negedge clk);
                chk("b_stall_valid", BVALID, 1);
                chk("b_stall_awready", AWREADY, 0);
                send_aw(6'h04);
            end
        join
        send_w(32'h00000077, 4'b0001);
        wait_b(0, resp);
        chk("reg1_after_stall", reg_q[63:32], 32'h11BB3377);
        chk("reg3_after_stall", reg_q[127:96], 32'h55AA55AA);

        fork
            do_read(6'h08, 10, data, rresp);
            begin
                repeat (5) @(negedge clk);
                chk("r_stall_valid", RVALID, 1);
                chk("r_stall_arready", ARREADY, 0);
            end
        join
        chk("rd_stall_data", data, 32'hCAFEF00D);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] d, rd;
            logic [3:0]  s;
            logic [5:0]  ra;
            int op;
            op = int'($urandom_range(0, 2));
            a = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a = {2'b00, a[3:0]};
            ra = 6'($urandom_range(0, 19));
            d = $urandom;
            s = 4'($urandom);
            if (op == 0) begin
                do_write(a, d, s, int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), resp);
            end else if (op == 1) begin
                do_read(ra, int'($urandom_range(0, 3)), rd, rresp);
            end else begin
                fork
                    do_write(a, d, s, int'($urandom_range(0, 2)),
                             int'($urandom_range(0, 2)),
                             int'($urandom_range(0, 2)), resp);
                    do_read(ra, int'($urandom_range(0, 2)), rd, rresp);
                join
            end
        end

        do_write(6'h00, 32'hA5A5A5A5, 4'hF, 0, 0, 0, resp);
        send_aw(6'h00);
        #2 ARESET = 1'b1;
        @(negedge clk);
        #2 ARESET = 1'b0;
        @(negedge clk);
        send_w(32'hFFFFFFFF, 4'hF);
        repeat (5) @(negedge clk);
        chk("rst_abandon_bvalid", BVALID, 0);
        chk("rst_abandon_reg_q", reg_q, 0);
        for (int k = 0; k < 4; k++) begin
            do_read(6'(4*k), 0, data, rresp);
            chk("rd_after_rst", data, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axil_bomberman_reg_slave.md
Name: axil_bomberman_reg_slave

Overview:
AXI4-Lite responder (slave) register file for the bomberman controller IP, sitting behind the S00_AXI port that the VIP master bench drives.
- Holds NUM_REGS 32-bit read/write control registers.
- Exposes the register contents and per-register write pulses to the game fabric logic.
- Returns OKAY for mapped addresses and SLVERR for unmapped ones.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 6, byte address width; the decoded word index is addr[C_S_AXI_ADDR_WIDTH-1:2].
NUM_REGS, 4, number of implemented registers at byte offsets 0x00, 0x04, … (NUM_REGS-1)*4.

Ports:
ACLK  in  1  sole clock; all logic is rising-edge.
ARESET  in  1  asynchronous, active-high reset.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID  in  1  write address valid.
S_AXI_AWREADY  out  1  write address ready.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WVALID  in  1  write data valid.
S_AXI_WREADY  out  1  write data ready.
S_AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
S_AXI_BVALID  out  1  write response valid.
S_AXI_BREADY  in  1  write response ready.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID  in  1  read address valid.
S_AXI_ARREADY  out  1  read address ready.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID  out  1  read data valid.
S_AXI_RREADY  in  1  read data ready.
reg_q  out  NUM_REGS*32  flat register contents; register k occupies bits [32k+31:32k].
reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the register written.

Behaviour:
- Reset (asynchronous, ARESET=1):
  - All registers = 0.
  - AWREADY, WREADY, BVALID, ARREADY, RVALID, reg_wr_pulse = 0.
  - BRESP, RRESP, RDATA = 0.
  - aw_held and w_held flags cleared.
- First cycle after reset deassertion: AWREADY, WREADY, ARREADY = 1.
- A reset mid-transaction abandons the transaction; no partial register update occurs.
- Write path, one outstanding transaction:
  - AW and W channels are accepted independently, in either order.
  - AWREADY = !aw_held & !BVALID. WREADY = !w_held & !BVALID.
  - A handshake on a channel without the other sets that channel's held flag and latches its address or data+strobe.
  - Commit edge: the first edge where (AW handshake or aw_held) and (W handshake or w_held).
  - At the commit edge, for a mapped index: register[idx] byte b takes WDATA byte b where WSTRB[b]=1; other bytes keep their value. reg_wr_pulse[idx] = 1 for exactly one cycle, even if WSTRB = 0.
  - At the commit edge, for an unmapped index (idx >= NUM_REGS): no register changes and no pulse.
  - Also at the commit edge: BVALID <= 1, BRESP = OKAY or SLVERR, and both held flags clear.
  - Latency: AW and W in the same cycle → reg_q updates and BVALID rises one cycle later.
  - BVALID holds with a stable BRESP until BREADY. AWREADY and WREADY rise the cycle after the B handshake.
- Read path, one outstanding transaction:
  - ARREADY = !RVALID.
  - On an AR handshake, the next edge sets RVALID=1. RDATA = register[idx] and RRESP = OKAY if mapped; RDATA = 0 and RRESP = SLVERR if unmapped.
  - RDATA and RRESP stay stable while RVALID & !RREADY.
  - RVALID clears on the RREADY handshake; ARREADY returns the next cycle (maximum throughput: one read per 2 cycles).
- Simultaneous read and write commit on the same edge to the same register: RDATA returns the pre-write value.
- Address bits [1:0] are ignored; unaligned addresses map to the containing word.
- Read and write paths are fully independent; neither stalls the other.

Decomposition:
- Package bomberman_axil_pkg contains:
  - constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, ADDR_LSB = 2;
  - function strb_merge(old, wdata, wstrb) returning the 32-bit merged word.
- Sub-module axil_wr_capture holds the AW/W hold registers, the held flags and commit generation.
- The read path and the register array stay in the top module.

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to 0x00, 0x04, 0x08, 0x0C (AW+W same cycle, BREADY=1) → each BRESP=OKAY. reg_q = {0x4,0x3,0x2,0x1}. Reads return 1..4 with RRESP=OKAY. reg_wr_pulse bits 0..3 pulse once each.
- AW at 0x08 issued 3 cycles before W=0xDEADBEEF → AWREADY stays low after the handshake. BVALID rises one cycle after the W handshake. reg2 = 0xDEADBEEF. The W-before-AW order gives the same result.
- reg1 = 0x11223344, then write 0xAABBCCDD with WSTRB=4'b0101 → reg1 = 0x11BB33DD. A later write with WSTRB=0 leaves reg1 unchanged but pulses reg_wr_pulse[1].
- Write to 0x10 and read 0x3C → BRESP=SLVERR with no register change. RRESP=SLVERR with RDATA=0.
- BREADY held low 10 cycles → BVALID and BRESP stable; AWREADY and WREADY stay 0; a second AW is not accepted until after the B handshake. The same holds for RREADY low 10 cycles on the read side.
- Start a write with AW held, assert ARESET for 1 cycle, then send W only → no commit and no BVALID. Registers read back 0.
